// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions: round count, round-constant table, the key
// schedule FSM encoding and the 32-bit word type used by the key schedule.
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_NUM_ROUNDS = 10;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_DONE = 2'd2
   } key_state_t;

   // Rcon[1..10] is used; the remaining entries are zero so that any 4-bit
   // index is safe (the entry read while on the last round is never used).
   localparam logic [7:0] RCON_TABLE [0:15] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box for one byte.
// Ports:
//   in_byte   in  8  byte to substitute
//   out_byte  out 8  S-box(in_byte)
// The table is derived arithmetically: multiplicative inverse in GF(2^8)
// (x^254, which also maps 0 to 0) followed by the AES affine transform.
// ---------------------------------------------------------------------------
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            acc = acc ^ sh;
         end else begin
            acc = acc;
         end
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // x^254 = x^2 * x^4 * ... * x^128, the field inverse for x != 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] res;
      sq  = a;
      res = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         res = gf_mul(res, sq);
      end
      return res;
   endfunction

   function automatic logic [7:0] sbox_affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Byte substitution
   always_comb begin
      out_byte = sbox_affine(gf_inv(in_byte));
   end

endmodule

// File: rtl/aes_key_expansion.sv
// ---------------------------------------------------------------------------
// aes_key_expansion
// Iterative AES-128 key schedule: presents round keys 0..10 one at a time
// under a valid/ready handshake, then pulses done.
// Ports:
//   clk         in  1    clock, rising edge
//   rst         in  1    synchronous active-high reset
//   key_load    in  1    start; cipher_key captured when idle
//   cipher_key  in  128  AES key, w0 = [127:96]
//   busy        out 1    schedule in progress
//   rk_valid    out 1    round_key / round_idx valid
//   rk_ready    in  1    consumer accepts the current key
//   round_key   out 128  current round key
//   round_idx   out 4    index of round_key
//   done        out 1    one-cycle pulse after key 10 is accepted
// round_key is itself the key register: the next key is computed from it
// combinationally and written back on each handshake.
// ---------------------------------------------------------------------------
module aes_key_expansion
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_load,
   input  logic [127:0] cipher_key,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         done
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

   key_state_t state_r;

   word_t      w0_s, w1_s, w2_s, w3_s;
   word_t      rot_s;
   word_t      sub_s;
   word_t      t_s;
   word_t      n0_s, n1_s, n2_s, n3_s;
   logic [7:0] rcon_s;

   // RotWord of the last word: [a,b,c,d] -> [b,c,d,a]
   always_comb begin
      w0_s  = round_key[127:96];
      w1_s  = round_key[95:64];
      w2_s  = round_key[63:32];
      w3_s  = round_key[31:0];
      rot_s = {w3_s[23:0], w3_s[31:24]};
   end

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .in_byte  (rot_s[8*g +: 8]),
         .out_byte (sub_s[8*g +: 8])
      );
   end

   // Round constant mix and the word XOR chain for the next key
   always_comb begin
      rcon_s = RCON_TABLE[round_idx + 4'd1];
      t_s    = sub_s ^ {rcon_s, 24'h000000};
      n0_s   = w0_s ^ t_s;
      n1_s   = w1_s ^ n0_s;
      n2_s   = w2_s ^ n1_s;
      n3_s   = w3_s ^ n2_s;
   end

   // Schedule FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         busy      <= 1'b0;
         rk_valid  <= 1'b0;
         done      <= 1'b0;
         round_idx <= 4'd0;
         round_key <= 128'h0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (key_load) begin
                  round_key <= cipher_key;
                  round_idx <= 4'd0;
                  rk_valid  <= 1'b1;
                  busy      <= 1'b1;
                  state_r   <= ST_EMIT;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_EMIT: begin
               if (rk_ready) begin
                  if (round_idx == LAST_IDX) begin
                     rk_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state_r  <= ST_DONE;
                  end else begin
                     round_key <= {n0_s, n1_s, n2_s, n3_s};
                     round_idx <= round_idx + 4'd1;
                  end
               end else begin
                  state_r <= ST_EMIT;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy     <= 1'b0;
               rk_valid <= 1'b0;
               done     <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expansion.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expansion
// Self-checking bench for aes_key_expansion. A reference key schedule is
// computed from the FIPS-197 word recurrence using an S-box table generated
// by the log/antilog walk of GF(2^8).
// ---------------------------------------------------------------------------
module tb_aes_key_expansion;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic         clk;
   logic         rst;
   logic         key_load;
   logic [127:0] cipher_key;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         done;

   int errors = 0;
   int checks = 0;

   logic [7:0]   sbox_tab   [0:255];
   logic [127:0] model_keys [0:10];

   aes_key_expansion #(.NUM_ROUNDS(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_load   (key_load),
      .cipher_key (cipher_key),
      .busy       (busy),
      .rk_valid   (rk_valid),
      .rk_ready   (rk_ready),
      .round_key  (round_key),
      .round_idx  (round_idx),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then observed 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_tab[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_tab[0] = 8'h63;
   endtask

   task automatic build_model(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
            tmp[31:24] = tmp[31:24] ^ rc;
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // One-cycle load pulse; returns observing cycle T+1.
   task automatic load_key(input logic [127:0] key);
      key_load   = 1'b1;
      cipher_key = key;
      step();
      key_load   = 1'b0;
      cipher_key = rand_key();
   endtask

   task automatic test_reset();
      rst = 1'b1; key_load = 1'b0; rk_ready = 1'b0; cipher_key = 128'h0;
      step(); step();
      checks++;
      if ({rk_valid, busy, done} !== 3'b000 || round_idx !== 4'd0 || round_key !== 128'h0) begin
         errors++;
         $display("FAIL reset_values: valid=%0b busy=%0b done=%0b idx=%0d key=%h required all 0",
                  rk_valid, busy, done, round_idx, round_key);
      end
      rst = 1'b0;
      rk_ready = 1'b1;
      step(); step();
      checks++;
      if (rk_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ready_when_idle: valid=%0b busy=%0b required 0 0", rk_valid, busy);
      end
      rk_ready = 1'b0;
   endtask

   // Streams a key with rk_ready held high and checks every round plus done.
   task automatic test_stream(input logic [127:0] key, input logic [127:0] r1, input logic [127:0] r10);
      build_model(key);
      rk_ready = 1'b1;
      load_key(key);
      for (int k = 0; k <= 10; k++) begin
         checks++;
         if (rk_valid !== 1'b1 || busy !== 1'b1 || round_idx !== 4'(k) || round_key !== model_keys[k]) begin
            errors++;
            $display("FAIL stream_key%0d: valid=%0b busy=%0b idx=%0d key=%h required idx=%0d key=%h",
                     k, rk_valid, busy, round_idx, round_key, k, model_keys[k]);
         end
         if (k == 1) begin
            checks++;
            if (round_key !== r1) begin
               errors++;
               $display("FAIL vector_round1: got %h required %h", round_key, r1);
            end
         end
         if (k == 10) begin
            checks++;
            if (round_key !== r10) begin
               errors++;
               $display("FAIL vector_round10: got %h required %h", round_key, r10);
            end
         end
         step();
      end
      checks++;
      if (done !== 1'b1 || rk_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: done=%0b valid=%0b required 1 0", done, rk_valid);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_single: done=%0b busy=%0b required 0 0", done, busy);
      end
      rk_ready = 1'b0;
   endtask

   task automatic test_stall();
      int exp_idx;
      int cycles;
      logic [127:0] prev_key;
      logic [3:0]   prev_idx;
      logic         stalled;
      build_model(FIPS_KEY);
      rk_ready = 1'b0;
      load_key(FIPS_KEY);
      exp_idx = 0; cycles = 0; stalled = 1'b0;
      prev_key = 128'h0; prev_idx = 4'd0;
      while (exp_idx <= 10 && cycles < 300) begin
         checks++;
         if (rk_valid !== 1'b1 || round_idx !== 4'(exp_idx) || round_key !== model_keys[exp_idx]) begin
            errors++;
            $display("FAIL stall_key: valid=%0b idx=%0d key=%h required idx=%0d key=%h",
                     rk_valid, round_idx, round_key, exp_idx, model_keys[exp_idx]);
         end
         if (stalled) begin
            checks++;
            if (round_key !== prev_key || round_idx !== prev_idx) begin
               errors++;
               $display("FAIL stall_stable: idx=%0d key=%h required idx=%0d key=%h",
                        round_idx, round_key, prev_idx, prev_key);
            end
         end
         prev_key = round_key;
         prev_idx = round_idx;
         rk_ready = 1'($urandom_range(0, 1));
         stalled  = ~rk_ready;
         if (rk_ready) exp_idx++;
         step();
         cycles++;
      end
      checks++;
      if (cycles >= 300) begin
         errors++;
         $display("FAIL stall_timeout: reached %0d cycles, required under 300", cycles);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL stall_done: done=%0b required 1", done);
      end
      rk_ready = 1'b0;
      step();
   endtask

   task automatic test_load_ignored();
      build_model(FIPS_KEY);
      rk_ready = 1'b1;
      load_key(FIPS_KEY);
      for (int k = 0; k <= 10; k++) begin
         checks++;
         if (round_idx !== 4'(k) || round_key !== model_keys[k]) begin
            errors++;
            $display("FAIL midload_key%0d: idx=%0d key=%h required key=%h",
                     k, round_idx, round_key, model_keys[k]);
         end
         if (k == 4) begin
            key_load = 1'b1;
            cipher_key = rand_key();
         end else begin
            key_load = 1'b0;
         end
         step();
      end
      key_load = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL midload_done: done=%0b required 1", done);
      end
      rk_ready = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic [127:0] k2;
      rk_ready = 1'b1;
      load_key(rand_key());
      for (int k = 0; k < 6; k++) step();
      checks++;
      if (round_idx !== 4'd6) begin
         errors++;
         $display("FAIL rstmid_setup: idx=%0d required 6", round_idx);
      end
      rst = 1'b1;
      key_load = 1'b1;
      cipher_key = rand_key();
      step();
      rst = 1'b0;
      key_load = 1'b0;
      checks++;
      if ({rk_valid, busy, done} !== 3'b000 || round_idx !== 4'd0 || round_key !== 128'h0) begin
         errors++;
         $display("FAIL rstmid_values: valid=%0b busy=%0b done=%0b idx=%0d key=%h required all 0",
                  rk_valid, busy, done, round_idx, round_key);
      end
      rk_ready = 1'b0;
      k2 = rand_key();
      load_key(k2);
      checks++;
      if (rk_valid !== 1'b1 || round_idx !== 4'd0 || round_key !== k2) begin
         errors++;
         $display("FAIL rstmid_reload: valid=%0b idx=%0d key=%h required 1 0 %h",
                  rk_valid, round_idx, round_key, k2);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic [127:0] kb;
      kb = rand_key();
      rk_ready = 1'b1;
      load_key(FIPS_KEY);
      for (int k = 0; k <= 10; k++) step();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done: done=%0b required 1", done);
      end
      key_load = 1'b1;
      cipher_key = rand_key();
      step();
      checks++;
      if (rk_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done_load_ignored: valid=%0b done=%0b required 0 0", rk_valid, done);
      end
      build_model(kb);
      load_key(kb);
      for (int k = 0; k <= 10; k++) begin
         checks++;
         if (rk_valid !== 1'b1 || round_idx !== 4'(k) || round_key !== model_keys[k]) begin
            errors++;
            $display("FAIL b2b_key%0d: valid=%0b idx=%0d key=%h required key=%h",
                     k, rk_valid, round_idx, round_key, model_keys[k]);
         end
         step();
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_done: done=%0b required 1", done);
      end
      rk_ready = 1'b0;
      step();
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_stream(FIPS_KEY, FIPS_R1, FIPS_R10);
      test_stream(128'h0, ZERO_R1, ZERO_R10);
      test_stall();
      test_load_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
